counter52_accum: RTL and testbench
==================================

Name: counter52_accum

Overview:
- Downstream consumer of the 5:2 counter stage. Each beat takes one (s, c) pair, where s has weight 1 and c has weight 2, and adds s + 2·c to a running total.
- Sums over a programmable frame of beats, giving the population count of a serialised bit stream that has been compressed five bits at a time.
- Frame start uses a pulse; input and output use valid/ready handshakes so the block can be back-pressured by the next stage.

Parameters:
- LEN_W, 8: width of frame length (beats per frame, 0 to 2^LEN_W-1).
- ACC_W, 11: width of the accumulated total. The default holds 3·255 without overflow.

Ports:
- clk, input, 1: the only clock; all state updates on the rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- start, input, 1: one-cycle frame start; sampled only in IDLE.
- len, input, LEN_W: beats in the frame; latched when start is accepted.
- in_valid, input, 1: the (s, c) pair is valid this cycle.
- in_ready, output, 1: block accepts a beat this cycle.
- s, input, 1: sum bit from the 5:2 counter, weight 1.
- c, input, 1: carry bit from the 5:2 counter, weight 2.
- out_valid, output, 1: total is final and stable.
- out_ready, input, 1: consumer takes the total.
- total, output, ACC_W: accumulated frame count.
- overflow, output, 1: sticky per frame; the sum exceeded 2^ACC_W-1.

Behaviour:
- Reset (async assert, sync release): state=IDLE, in_ready=0, out_valid=0, total=0, overflow=0, internal remaining count=0.
- States:
  - IDLE:
    - in_ready=0, out_valid=0.
    - On start=1 with len≠0: latch remaining=len, clear total and overflow, go to RUN.
    - On start=1 with len=0: clear total and overflow, go directly to HOLD.
  - RUN:
    - in_ready=1.
    - A beat is accepted when in_valid&&in_ready.
    - On each accepted beat: total += {c,s} (0..3), remaining -= 1.
    - If remaining was 1 at acceptance, go to HOLD next cycle.
    - Cycles with in_valid=0 leave total and remaining unchanged.
  - HOLD:
    - in_ready=0, out_valid=1, total and overflow held stable.
    - On out_ready=1: go to IDLE. out_valid drops the following cycle; total keeps its value until the next accepted start.
- start is ignored in RUN and HOLD; there is no queuing or restart mid-frame.
- Latency:
  - out_valid rises exactly 1 cycle after the last beat is accepted.
  - For len=0, out_valid rises 1 cycle after start.
  - Earliest next start is the cycle after the HOLD handshake, i.e. 1 idle cycle minimum.
- Arithmetic: beat value is the 2-bit unsigned {c,s}, zero-extended to ACC_W+1 bits for the add.
- Overflow: set when the carry out of bit ACC_W-1 is 1. Stays set until the next accepted start or reset.
- s and c are ignored whenever no beat is accepted.
- Reset mid-frame: any state returns to IDLE immediately; the partial total is discarded (total=0).

Optional Feature:
- Macro: COUNTER52_SATURATE_EN.
- Defined:
  - On overflow, total clamps to 2^ACC_W-1 and stays there for the rest of the frame.
  - overflow is set on the clamping beat.
- Not defined:
  - total wraps modulo 2^ACC_W.
  - overflow is still set on the wrapping beat and is sticky.
- Port list is identical in both builds.

Test Plan:
- Basic frame: len=4, beats (s,c)=(1,0),(0,1),(1,1),(0,0), in_valid continuous, out_ready=1 → out_valid one cycle after 4th beat; total=6, overflow=0; IDLE next cycle.
- Zero-length frame: start with len=0 → in_ready never 1; out_valid=1 the cycle after start; total=0.
- Stalls and back-pressure:
  - Input side: len=3, all beats (1,1), in_valid toggling 1,0,0,1,0,1 → only 3 beats counted, total=9.
  - Output side: hold out_ready=0 for 5 cycles → total=9 stays stable and out_valid stays 1.
  - Ignored start: start pulsed during RUN and during HOLD → no effect.
- Overflow (ACC_W=4, len=6, all beats (1,1), true sum 18):
  - Without macro → total=2, overflow=1.
  - With COUNTER52_SATURATE_EN → total=15, overflow=1.
  - Next frame start → overflow=0.
- Reset mid-frame: assert rst_n=0 asynchronously after 2 of 5 beats → all outputs 0 and state IDLE without waiting for a clk edge; fresh frame len=2, (1,0),(1,0) → total=2.

Source files
------------

// File: rtl/counter52_accum.sv
// counter52_accum: frame accumulator behind a 5:2 counter stage.
// Each accepted beat adds the 2-bit value {c,s} to a running total. The frame length is
// latched on start, and the final total is presented with a valid/ready handshake.
// Build option: define COUNTER52_SATURATE_EN to clamp the total at 2^ACC_W-1 on overflow.
// Without it the total wraps. The overflow flag is sticky in both builds.
module counter52_accum #(
  parameter int unsigned LEN_W = 8,
  parameter int unsigned ACC_W = 11
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             s,
  input  logic             c,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] total,
  output logic             overflow
);

  typedef enum logic [1:0] {StIdle, StRun, StHold} state_e;

  state_e             state_q, state_d;
  logic [LEN_W-1:0]   remaining_q, remaining_d;
  logic [ACC_W-1:0]   total_q, total_d;
  logic               overflow_q, overflow_d;
  logic [ACC_W:0]     acc_sum;
  logic               beat_acc;

  // Outputs decode directly from state, so they are glitch-free and registered.
  always_comb begin
    in_ready  = (state_q == StRun);
    out_valid = (state_q == StHold);
    total     = total_q;
    overflow  = overflow_q;
  end

  // One extra bit catches the carry out of the top accumulator bit.
  always_comb begin
    beat_acc = in_valid && (state_q == StRun);
    acc_sum  = {1'b0, total_q} + {{(ACC_W - 1){1'b0}}, c, s};
  end

  // Next-state logic for the frame FSM and the datapath registers.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    total_d     = total_q;
    overflow_d  = overflow_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          total_d    = '0;
          overflow_d = 1'b0;
          if (len == '0) begin
            state_d = StHold;
          end else begin
            remaining_d = len;
            state_d     = StRun;
          end
        end
      end
      StRun: begin
        if (beat_acc) begin
`ifdef COUNTER52_SATURATE_EN
          // Once clamped the total stays at full scale for the rest of the frame.
          if (overflow_q || acc_sum[ACC_W]) begin
            total_d = '1;
          end else begin
            total_d = acc_sum[ACC_W-1:0];
          end
`else
          total_d = acc_sum[ACC_W-1:0];
`endif
          overflow_d  = overflow_q | acc_sum[ACC_W];
          remaining_d = remaining_q - LEN_W'(1);
          if (remaining_q == LEN_W'(1)) begin
            state_d = StHold;
          end
        end
      end
      StHold: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State registers; reset discards any partial frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      remaining_q <= '0;
      total_q     <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      total_q     <= total_d;
      overflow_q  <= overflow_d;
    end
  end

endmodule

// File: tb/tb_counter52_accum.sv
// Bench for counter52_accum, built with ACC_W=4 so the overflow cases are reachable.
// Define COUNTER52_SATURATE_EN here too when building the saturating variant.
module tb_counter52_accum;

  localparam int unsigned LEN_W = 8;
  localparam int unsigned ACC_W = 4;
  localparam int          MAXV  = (1 << ACC_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             start = 1'b0;
  logic [LEN_W-1:0] len = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic             s = 1'b0;
  logic             c = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [ACC_W-1:0] total;
  logic             overflow;

  int n_cmp  = 0;
  int n_fail = 0;

  counter52_accum #(.LEN_W(LEN_W), .ACC_W(ACC_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .len       (len),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .s         (s),
    .c         (c),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .total     (total),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  // Frame-level model: phase 0 waiting, 1 collecting beats, 2 result offered.
  int phase    = 0;
  int left     = 0;
  int true_sum = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase    = 0;
      left     = 0;
      true_sum = 0;
    end else begin
      case (phase)
        0: if (start) begin
          true_sum = 0;
          if (len == 0) phase = 2;
          else begin
            left  = int'(len);
            phase = 1;
          end
        end
        1: if (in_valid) begin
          true_sum = true_sum + int'(s) + 2 * int'(c);
          left     = left - 1;
          if (left == 0) phase = 2;
        end
        default: if (out_ready) phase = 0;
      endcase
    end
  end

  function automatic int model_total();
`ifdef COUNTER52_SATURATE_EN
    return (true_sum > MAXV) ? MAXV : true_sum;
`else
    return true_sum % (MAXV + 1);
`endif
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Every cycle, away from the rising edge, the DUT must match the model.
  always @(negedge clk) begin
    check("cyc_in_ready", int'(in_ready), int'(phase == 1));
    check("cyc_out_valid", int'(out_valid), int'(phase == 2));
    check("cyc_total", int'(total), model_total());
    check("cyc_overflow", int'(overflow), int'(true_sum > MAXV));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic v, input logic bs, input logic bc);
    in_valid = v;
    s        = bs;
    c        = bc;
    step();
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #2;
    check("reset_total", int'(total), 0);
    check("reset_flags", int'({in_ready, out_valid, overflow}), 0);
    step();
    rst_n = 1'b1;
    step();

    // Basic frame: 1 + 2 + 3 + 0 = 6.
    start = 1'b1; len = 8'd4; step();
    start = 1'b0;
    beat(1, 1, 0); beat(1, 0, 1); beat(1, 1, 1); beat(1, 0, 0);
    in_valid = 1'b0;
    check("basic_out_valid", int'(out_valid), 1);
    check("basic_total", int'(total), 6);
    check("basic_model", model_total(), 6);
    check("basic_overflow", int'(overflow), 0);
    step();
    check("basic_idle", int'(out_valid), 0);
    check("basic_total_kept", int'(total), 6);

    // Zero-length frame goes straight to the result.
    start = 1'b1; len = 8'd0; step();
    start = 1'b0;
    check("zero_out_valid", int'(out_valid), 1);
    check("zero_in_ready", int'(in_ready), 0);
    check("zero_total", int'(total), 0);
    step();

    // Input stalls, a start pulse mid-frame, then output back-pressure.
    out_ready = 1'b0;
    start = 1'b1; len = 8'd3; step();
    start = 1'b0;
    beat(1, 1, 1); beat(0, 1, 1);
    start = 1'b1; len = 8'd7;
    beat(0, 1, 1);
    start = 1'b0;
    beat(1, 1, 1); beat(0, 1, 1); beat(1, 1, 1);
    in_valid = 1'b0;
    check("stall_out_valid", int'(out_valid), 1);
    check("stall_total", int'(total), 9);
    start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 5; i++) step();
    check("hold_out_valid", int'(out_valid), 1);
    check("hold_total", int'(total), 9);
    check("hold_model", model_total(), 9);
    out_ready = 1'b1; step();
    check("hold_release", int'(out_valid), 0);
    step();

    // Overflow: true sum 18 in a 4-bit accumulator.
    start = 1'b1; len = 8'd6; step();
    start = 1'b0;
    for (int i = 0; i < 6; i++) beat(1, 1, 1);
    in_valid = 1'b0;
    check("ovf_overflow", int'(overflow), 1);
`ifdef COUNTER52_SATURATE_EN
    check("ovf_total", int'(total), 15);
    check("ovf_model", model_total(), 15);
`else
    check("ovf_total", int'(total), 2);
    check("ovf_model", model_total(), 2);
`endif
    step();
    check("ovf_sticky_idle", int'(overflow), 1);
    start = 1'b1; len = 8'd1; step();
    start = 1'b0;
    check("ovf_cleared", int'(overflow), 0);
    check("ovf_total_cleared", int'(total), 0);
    beat(1, 1, 0);
    in_valid = 1'b0;
    check("after_ovf_total", int'(total), 1);
    step();

    // Asynchronous reset after 2 of 5 beats.
    start = 1'b1; len = 8'd5; step();
    start = 1'b0;
    beat(1, 1, 1); beat(1, 0, 1);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("arst_total", int'(total), 0);
    check("arst_flags", int'({in_ready, out_valid, overflow}), 0);
    step();
    rst_n = 1'b1;
    step();
    start = 1'b1; len = 8'd2; step();
    start = 1'b0;
    beat(1, 1, 0); beat(1, 1, 0);
    in_valid = 1'b0;
    check("fresh_out_valid", int'(out_valid), 1);
    check("fresh_total", int'(total), 2);
    step();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
